// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: applies every input vector to a combinational block, samples it and
// compares the captured table against an expected mask. Define SWEEP_GRAY_EN for Gray-order sweeps.
module truth_table_sweeper #(
    parameter int unsigned N_IN   = 4,
    parameter int unsigned SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2**N_IN-1:0]   expected,
    output logic [N_IN-1:0]      dut_in,
    input  logic                 dut_out,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   captured_table,
    output logic [N_IN:0]        err_count,
    output logic                 mismatch
);

    localparam logic [N_IN-1:0] LastIdx = {N_IN{1'b1}};
    localparam logic [N_IN:0]   ErrOne  = 1;
    localparam logic [3:0]      SettleLoad = 4'(SETTLE);

    typedef enum logic [2:0] {
        StIdle,
        StApply,
        StWait,
        StSample,
        StDone
    } state_e;

    state_e               state_q;
    logic [N_IN-1:0]      idx_q;
    logic [3:0]           settle_q;
    logic [2**N_IN-1:0]   expected_q;
    logic [N_IN-1:0]      vec;

    // The table stays indexed by input value whichever order the sweep walks.
    always_comb begin
`ifdef SWEEP_GRAY_EN
        vec = idx_q ^ (idx_q >> 1);
`else
        vec = idx_q;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            idx_q          <= '0;
            settle_q       <= '0;
            expected_q     <= '0;
            dut_in         <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            captured_table <= '0;
            err_count      <= '0;
            mismatch       <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        state_q        <= StApply;
                        expected_q     <= expected;
                        captured_table <= '0;
                        err_count      <= '0;
                        mismatch       <= 1'b0;
                        idx_q          <= '0;
                        busy           <= 1'b1;
                    end
                end
                StApply: begin
                    dut_in   <= vec;
                    settle_q <= SettleLoad;
                    state_q  <= (SETTLE > 0) ? StWait : StSample;
                end
                StWait: begin
                    settle_q <= settle_q - 4'd1;
                    if (settle_q <= 4'd1) begin
                        state_q <= StSample;
                    end
                end
                StSample: begin
                    captured_table[vec] <= dut_out;
                    if (dut_out != expected_q[vec]) begin
                        err_count <= err_count + ErrOne;
                        mismatch  <= 1'b1;
                    end
                    if (idx_q == LastIdx) begin
                        state_q <= StDone;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        state_q <= StApply;
                    end
                end
                StDone: begin
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper with f=(a&b)|(c&d); one instance with SETTLE=1, one with SETTLE=0.
module tb_truth_table_sweeper;

    typedef struct packed {
        logic [15:0] tbl;
        logic [4:0]  err;
        logic        mis;
    } result_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic [15:0] expected_a = '0, expected_b = '0;
    logic [3:0]  dut_in_a, dut_in_b;
    logic        dut_out_a, dut_out_b;
    logic        busy_a, busy_b, done_a, done_b, mis_a, mis_b;
    logic [15:0] table_a, table_b;
    logic [4:0]  err_a, err_b;

    int tests = 0;
    int fails = 0;
    result_t sb_a[$];
    result_t sb_b[$];

    always #5 clk = ~clk;

    function automatic logic f_model(input logic [3:0] v);
        return (v[3] & v[2]) | (v[1] & v[0]);
    endfunction

    function automatic result_t model(input logic [15:0] exp);
        result_t r;
        r.tbl = '0;
        for (int k = 0; k < 16; k++) r.tbl[k] = f_model(4'(k));
        r.err = '0;
        for (int k = 0; k < 16; k++) if (r.tbl[k] != exp[k]) r.err = r.err + 5'd1;
        r.mis = (r.err != 0);
        return r;
    endfunction

    function automatic logic [3:0] vec_model(input int j);
        logic [3:0] v;
        v = 4'(j);
`ifdef SWEEP_GRAY_EN
        v = v ^ (v >> 1);
`endif
        return v;
    endfunction

    assign dut_out_a = f_model(dut_in_a);
    assign dut_out_b = f_model(dut_in_b);

    truth_table_sweeper #(.N_IN(4), .SETTLE(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .expected(expected_a), .dut_in(dut_in_a),
        .dut_out(dut_out_a), .busy(busy_a), .done(done_a), .captured_table(table_a),
        .err_count(err_a), .mismatch(mis_a)
    );

    truth_table_sweeper #(.N_IN(4), .SETTLE(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .expected(expected_b), .dut_in(dut_in_b),
        .dut_out(dut_out_b), .busy(busy_b), .done(done_b), .captured_table(table_b),
        .err_count(err_b), .mismatch(mis_b)
    );

    // Start a sweep on instance A; cycle k is #1 after the k-th edge following the start edge.
    task automatic sweep_a(input logic [15:0] exp, input bit hold, input int poke_at,
                           output int done_cyc, output int busy_cyc);
        int k;
        sb_a.push_back(model(exp));
        expected_a = exp;
        start_a = 1'b1;
        @(posedge clk); #1;
        k = 1;
        done_cyc = 0;
        busy_cyc = 0;
        start_a = hold;
        while (done_cyc == 0 && k < 300) begin
            if (busy_a) busy_cyc++;
            if (done_a) done_cyc = k;
            else begin
                start_a = hold || (k == poke_at);
                if (k == 5) expected_a = ~exp;
                @(posedge clk); #1;
                k++;
            end
        end
    endtask

    task automatic test_reset;
        #3 rst_n = 1'b0;
        #1;
        tests++;
        if ({dut_in_a, busy_a, done_a, table_a, err_a, mis_a} !== '0 ||
            {dut_in_b, busy_b, done_b, table_b, err_b, mis_b} !== '0) begin
            fails++;
            $display("FAIL reset: a=%h b=%h want 0",
                     {dut_in_a, busy_a, done_a, table_a, err_a, mis_a},
                     {dut_in_b, busy_b, done_b, table_b, err_b, mis_b});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int d, b;
        result_t r;
        sweep_a(16'hF888, 1'b0, 0, d, b);
        tests++;
        if (d !== 49 || b !== 48) begin
            fails++;
            $display("FAIL basic_timing: done_cycle=%0d busy_cycles=%0d want 49/48", d, b);
        end
        r = sb_a.pop_front();
        tests++;
        if (table_a !== r.tbl || err_a !== r.err || mis_a !== r.mis) begin
            fails++;
            $display("FAIL basic_result: got %h/%0d/%b want %h/%0d/%b",
                     table_a, err_a, mis_a, r.tbl, r.err, r.mis);
        end
        @(posedge clk); #1;
        tests++;
        if (done_a !== 1'b0 || busy_a !== 1'b0) begin
            fails++;
            $display("FAIL done_pulse: done=%b busy=%b after DONE want 0/0", done_a, busy_a);
        end
    endtask

    task automatic test_errors;
        int d, b;
        result_t r;
        logic [15:0] masks [2];
        masks[0] = 16'hF889;
        masks[1] = 16'h0777;
        for (int i = 0; i < 2; i++) begin
            sweep_a(masks[i], 1'b0, 0, d, b);
            r = sb_a.pop_front();
            tests++;
            if (d !== 49 || table_a !== r.tbl || err_a !== r.err || mis_a !== r.mis) begin
                fails++;
                $display("FAIL errors_%h: got d=%0d %h/%0d/%b want d=49 %h/%0d/%b", masks[i],
                         d, table_a, err_a, mis_a, r.tbl, r.err, r.mis);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_ignore_start;
        int d, b;
        result_t r;
        sweep_a(16'hF889, 1'b0, 10, d, b);
        r = sb_a.pop_front();
        tests++;
        if (d !== 49 || b !== 48 || table_a !== r.tbl || err_a !== r.err || mis_a !== r.mis) begin
            fails++;
            $display("FAIL ignore_busy: got d=%0d b=%0d %h/%0d want d=49 b=48 %h/%0d",
                     d, b, table_a, err_a, r.tbl, r.err);
        end
        start_a = 1'b1;  // offered during DONE
        @(posedge clk); #1;
        start_a = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (busy_a !== 1'b0 || done_a !== 1'b0 || err_a !== r.err || table_a !== r.tbl) begin
            fails++;
            $display("FAIL ignore_done: busy=%b done=%b err=%0d want 0/0/%0d",
                     busy_a, done_a, err_a, r.err);
        end
    endtask

    task automatic test_back_to_back;
        int d, b, k;
        result_t r;
        sweep_a(16'hF888, 1'b1, 0, d, b);
        r = sb_a.pop_front();
        tests++;
        if (d !== 49 || table_a !== r.tbl || err_a !== r.err) begin
            fails++;
            $display("FAIL b2b_first: d=%0d %h/%0d want 49 %h/%0d", d, table_a, err_a, r.tbl, r.err);
        end
        expected_a = 16'hF888;
        sb_a.push_back(model(16'hF888));
        @(posedge clk); #1;
        tests++;
        if (busy_a !== 1'b0 || done_a !== 1'b0) begin
            fails++;
            $display("FAIL b2b_idle: busy=%b done=%b in cycle 50 want 0/0", busy_a, done_a);
        end
        @(posedge clk); #1;
        start_a = 1'b0;
        tests++;
        if (busy_a !== 1'b1) begin
            fails++;
            $display("FAIL b2b_apply: busy=%b in cycle 51 want 1", busy_a);
        end
        k = 51;
        d = 0;
        while (d == 0 && k < 300) begin
            if (done_a) d = k;
            else begin
                @(posedge clk); #1;
                k++;
            end
        end
        r = sb_a.pop_front();
        tests++;
        if (d !== 99 || table_a !== r.tbl || err_a !== r.err || mis_a !== r.mis) begin
            fails++;
            $display("FAIL b2b_second: d=%0d %h/%0d want 99 %h/%0d", d, table_a, err_a, r.tbl, r.err);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_sweep;
        int d, b, k;
        bit saw_done;
        result_t r;
        expected_a = 16'hF888;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        k = 0;
        while (dut_in_a !== 4'd7 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        tests++;
        if (dut_in_a !== 4'd7) begin
            fails++;
            $display("FAIL mid_reach7: dut_in=%h want 7", dut_in_a);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({dut_in_a, busy_a, done_a, table_a, err_a, mis_a} !== '0) begin
            fails++;
            $display("FAIL mid_reset: got %h want 0", {dut_in_a, busy_a, done_a, table_a, err_a, mis_a});
        end
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (60) begin
            @(posedge clk); #1;
            if (done_a || busy_a) saw_done = 1'b1;
        end
        tests++;
        if (saw_done) begin
            fails++;
            $display("FAIL mid_no_done: activity after reset got 1 want 0");
        end
        sweep_a(16'hF888, 1'b0, 0, d, b);
        r = sb_a.pop_front();
        tests++;
        if (d !== 49 || table_a !== r.tbl || err_a !== r.err || mis_a !== r.mis) begin
            fails++;
            $display("FAIL mid_resweep: d=%0d %h/%0d want 49 %h/%0d", d, table_a, err_a, r.tbl, r.err);
        end
    endtask

    task automatic test_settle0;
        int d, k, bad;
        result_t r;
        sb_b.push_back(model(16'hF888));
        expected_b = 16'hF888;
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        k = 1;
        d = 0;
        bad = 0;
        while (d == 0 && k < 200) begin
            if (k % 2 == 0 && k <= 32 && dut_in_b !== vec_model(k / 2 - 1)) bad++;
            if (done_b) d = k;
            else begin
                @(posedge clk); #1;
                k++;
            end
        end
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL settle0_order: %0d wrong vectors want 0", bad);
        end
        r = sb_b.pop_front();
        tests++;
        if (d !== 33 || table_b !== r.tbl || err_b !== r.err || mis_b !== r.mis) begin
            fails++;
            $display("FAIL settle0: d=%0d %h/%0d want 33 %h/%0d", d, table_b, err_b, r.tbl, r.err);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_errors;
        test_ignore_start;
        test_back_to_back;
        test_reset_mid_sweep;
        test_settle0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
